mux_arbiter_ctrl: RTL and testbench
===================================

Name: mux_arbiter_ctrl

Overview:
- Arbitrates two 8-bit byte sources onto one shared 8-bit path and drives the select of a 2:1 8-bit mux.
- Registers the chosen byte into a one-entry output stage with a valid/ready handshake toward the consumer.
- Sits between two producer units (e.g. register-file readback and memory readback) and a single downstream byte consumer in the processor datapath.
- Round-robin by default; fixed priority is selectable by parameter.

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins; 0 = round-robin.
- CNT_W, 8, width of the per-requester accepted-transfer counters.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 has a byte; held until ack0
- data0  input  8  requester 0 byte; stable while req0=1
- ack0  output  1  combinational; byte from requester 0 accepted this cycle
- req1  input  1  requester 1 has a byte; held until ack1
- data1  input  8  requester 1 byte; stable while req1=1
- ack1  output  1  combinational; byte from requester 1 accepted this cycle
- mux_sel  output  1  current arbitration choice, drives the shared mux select (0=data0, 1=data1)
- out_data  output  8  registered byte to consumer
- out_valid  output  1  out_data holds an unconsumed byte
- out_ready  input  1  consumer accepts out_data when out_valid=1
- cnt0  output  CNT_W  bytes accepted from requester 0, wraps
- cnt1  output  CNT_W  bytes accepted from requester 1, wraps

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_data=8'h00, cnt0=0, cnt1=0, last_sel=1 (internal), state=EMPTY. ack0 and ack1 evaluate to 0 because out_valid=0 and req are ignored while rst_n=0. mux_sel evaluates per its rule below.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- space = (state==EMPTY) | out_ready.
- Arbitration, combinational:
  - Only req0 set: choose 0. Only req1 set: choose 1.
  - Both set, FIXED_PRIO=1: choose 0.
  - Both set, FIXED_PRIO=0: choose ~last_sel.
  - Neither set: mux_sel = last_sel.
- load = space & (req0|req1). ack0 = load & (choice==0). ack1 = load & (choice==1). ack0 and ack1 are never both 1.
- On clk rising edge with load:
  - out_data <= choice ? data1 : data0
  - out_valid <= 1
  - last_sel <= choice
  - matching cnt increments by 1 (wraps modulo 2^CNT_W)
  - state -> FULL
- On clk rising edge with FULL & out_ready & ~load: out_valid <= 0, state -> EMPTY. out_data holds its last value.
- FULL & ~out_ready: all registers hold, no ack.
- Simultaneous drain and load (FULL & out_ready & req): new byte replaces old in the same edge; out_valid stays 1. This gives full throughput of one byte per cycle.
- Latency: a byte acked in cycle N appears on out_data/out_valid in cycle N+1.
- Fairness: with both requesting continuously under round-robin, grants alternate 0,1,0,1...; the first grant after reset goes to 0.
- Requester dropping req without ack: legal. No ack is issued and no state changes for that requester.
- rst_n asserted mid-transfer: a pending out_data is discarded, out_valid=0 immediately (asynchronous), counters cleared. Operation resumes on the first clk edge after deassertion.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, no req -> out_valid=0, out_data=00, cnt0=cnt1=0, ack0=ack1=0.
- Single requester: req0=1, data0=8'hA5, out_ready=1 -> ack0=1 in cycle N, out_data=A5 and out_valid=1 in N+1, cnt0=1; deassert req0 -> out_valid=0 one cycle after consumption.
- Round-robin contention: req0=req1=1 held, data0=11, data1=22, out_ready=1 for 6 cycles -> out_data sequence 11,22,11,22,11,22; cnt0=cnt1=3; ack never both 1.
- Backpressure: out_ready=0 with out_valid=1 and req1=1, data1=3C -> ack1=0, out_data unchanged for 4 cycles. Raise out_ready -> ack1=1 the same cycle, out_data=3C the next cycle, out_valid stays 1.
- Fixed priority with FIXED_PRIO=1: both req held 4 cycles -> only ack0 asserted, cnt0=4, cnt1=0.
- Async reset mid-stream: assert rst_n=0 between edges while out_valid=1 -> out_valid=0 and counters=0 before the next edge. After release, the first contention grant goes to requester 0.

Source files
------------

// File: rtl/mux_arbiter_ctrl_if.sv
// Byte-source / consumer bundle for the two-way byte arbiter.
// Producers and the consumer sit on the master side; the arbiter is the slave.
interface mux_arbiter_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             req0;
  logic [7:0]       data0;
  logic             ack0;
  logic             req1;
  logic [7:0]       data1;
  logic             ack1;
  logic             mux_sel;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0, data0, req1, data1, out_ready,
    input  ack0, ack1, mux_sel, out_data, out_valid, cnt0, cnt1
  );

  modport slave (
    input  req0, data0, req1, data1, out_ready,
    output ack0, ack1, mux_sel, out_data, out_valid, cnt0, cnt1
  );
endinterface

// File: rtl/mux_arbiter_ctrl.sv
// Two-way byte arbiter feeding a one-entry registered output stage with a
// valid/ready handshake; round-robin or fixed priority, per-source counters.
module mux_arbiter_ctrl #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_arbiter_ctrl_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic             last_sel;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic req0_ok;
  logic req1_ok;
  logic choice;
  logic space;
  logic load;

  // Requests are ignored while reset is held so no ack leaks out during reset.
  assign req0_ok = bus.req0 & rst_n;
  assign req1_ok = bus.req1 & rst_n;

  always_comb begin
    choice = last_sel;
    if (req0_ok && !req1_ok) begin
      choice = 1'b0;
    end else if (req1_ok && !req0_ok) begin
      choice = 1'b1;
    end else if (req0_ok && req1_ok) begin
      choice = FIXED_PRIO ? 1'b0 : ~last_sel;
    end
  end

  assign space = (state == EMPTY) | bus.out_ready;
  assign load  = space & (req0_ok | req1_ok);

  assign bus.ack0      = load & ~choice;
  assign bus.ack1      = load & choice;
  assign bus.mux_sel   = choice;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state == FULL);
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

  // A load during a drain simply overwrites the stage, giving one byte per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      last_sel <= 1'b1;
      data_q   <= 8'h00;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else if (load) begin
      state    <= FULL;
      last_sel <= choice;
      data_q   <= choice ? bus.data1 : bus.data0;
      if (choice) begin
        cnt1_q <= cnt1_q + 1'b1;
      end else begin
        cnt0_q <= cnt0_q + 1'b1;
      end
    end else if ((state == FULL) && bus.out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_arbiter_ctrl.sv
// Bench for mux_arbiter_ctrl: a round-robin and a fixed-priority instance share
// stimulus and are each compared against a rule-level reference model.
module tb_mux_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  mux_arbiter_ctrl_if #(.CNT_W(8)) bus_rr ();
  mux_arbiter_ctrl_if #(.CNT_W(8)) bus_fp ();

  assign bus_rr.req0      = req0;
  assign bus_rr.req1      = req1;
  assign bus_rr.data0     = data0;
  assign bus_rr.data1     = data1;
  assign bus_rr.out_ready = out_ready;
  assign bus_fp.req0      = req0;
  assign bus_fp.req1      = req1;
  assign bus_fp.data0     = data0;
  assign bus_fp.data1     = data1;
  assign bus_fp.out_ready = out_ready;

  mux_arbiter_ctrl #(.FIXED_PRIO(1'b0), .CNT_W(8)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_rr)
  );

  mux_arbiter_ctrl #(.FIXED_PRIO(1'b1), .CNT_W(8)) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fp)
  );

  // Index 0 is the round-robin instance, index 1 the fixed-priority one.
  logic       o_ack0 [2];
  logic       o_ack1 [2];
  logic       o_sel  [2];
  logic       o_valid[2];
  logic [7:0] o_data [2];
  logic [7:0] o_cnt0 [2];
  logic [7:0] o_cnt1 [2];

  assign o_ack0[0]  = bus_rr.ack0;
  assign o_ack1[0]  = bus_rr.ack1;
  assign o_sel[0]   = bus_rr.mux_sel;
  assign o_valid[0] = bus_rr.out_valid;
  assign o_data[0]  = bus_rr.out_data;
  assign o_cnt0[0]  = bus_rr.cnt0;
  assign o_cnt1[0]  = bus_rr.cnt1;
  assign o_ack0[1]  = bus_fp.ack0;
  assign o_ack1[1]  = bus_fp.ack1;
  assign o_sel[1]   = bus_fp.mux_sel;
  assign o_valid[1] = bus_fp.out_valid;
  assign o_data[1]  = bus_fp.out_data;
  assign o_cnt0[1]  = bus_fp.cnt0;
  assign o_cnt1[1]  = bus_fp.cnt1;

  int checks = 0;
  int failures = 0;
  bit hold_reqs = 1'b0;

  bit         m_valid[2];
  logic [7:0] m_data [2];
  bit         m_last [2];
  logic [7:0] m_cnt0 [2];
  logic [7:0] m_cnt1 [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 8'h00;
      m_last[k]  = 1'b1;
      m_cnt0[k]  = 8'h00;
      m_cnt1[k]  = 8'h00;
    end
  endtask

  function automatic bit modelChoice(input int k);
    if (req0 && !req1) return 1'b0;
    if (req1 && !req0) return 1'b1;
    if (req0 && req1)  return (k == 1) ? 1'b0 : !m_last[k];
    return m_last[k];
  endfunction

  // One clock: check combinational grant, advance the model, check registers.
  task automatic stepCycle();
    bit ch[2];
    bit ld[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      ch[k] = modelChoice(k);
      ld[k] = (!m_valid[k] || out_ready) && (req0 || req1);
      checkOutput($sformatf("dut%0d ack0", k), 32'(o_ack0[k]), 32'(ld[k] && !ch[k]));
      checkOutput($sformatf("dut%0d ack1", k), 32'(o_ack1[k]), 32'(ld[k] && ch[k]));
      checkOutput($sformatf("dut%0d mux_sel", k), 32'(o_sel[k]), 32'(ch[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld[k]) begin
        m_data[k]  = ch[k] ? data1 : data0;
        m_valid[k] = 1'b1;
        m_last[k]  = ch[k];
        if (ch[k]) m_cnt1[k] = m_cnt1[k] + 8'd1;
        else       m_cnt0[k] = m_cnt0[k] + 8'd1;
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d out_valid", k), 32'(o_valid[k]), 32'(m_valid[k]));
      checkOutput($sformatf("dut%0d out_data", k), 32'(o_data[k]), 32'(m_data[k]));
      checkOutput($sformatf("dut%0d cnt0", k), 32'(o_cnt0[k]), 32'(m_cnt0[k]));
      checkOutput($sformatf("dut%0d cnt1", k), 32'(o_cnt1[k]), 32'(m_cnt1[k]));
    end
    if (!hold_reqs) begin
      if (ld[0] && !ch[0]) req0 = 1'b0;
      if (ld[0] && ch[0])  req1 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    out_ready = ($urandom_range(0, 9) < 7);
    if (!req0) begin
      if ($urandom_range(0, 1) == 1) begin
        req0  = 1'b1;
        data0 = 8'($urandom);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      req0 = 1'b0;
    end
    if (!req1) begin
      if ($urandom_range(0, 1) == 1) begin
        req1  = 1'b1;
        data1 = 8'($urandom);
      end
    end else if ($urandom_range(0, 7) == 0) begin
      req1 = 1'b0;
    end
  endtask

  initial begin
    resetModel();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stepCycle();

    // Sustained contention straight out of reset: round-robin starts at 0.
    hold_reqs = 1'b1;
    req0 = 1'b1; data0 = 8'h11;
    req1 = 1'b1; data1 = 8'h22;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("rr sequence", 32'(o_data[0]), (i % 2 == 0) ? 32'h11 : 32'h22);
      checkOutput("fp sequence", 32'(o_data[1]), 32'h11);
    end
    hold_reqs = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("rr cnt0 after contention", 32'(o_cnt0[0]), 32'd3);
    checkOutput("rr cnt1 after contention", 32'(o_cnt1[0]), 32'd3);
    checkOutput("fp cnt0 after contention", 32'(o_cnt0[1]), 32'd6);
    checkOutput("fp cnt1 after contention", 32'(o_cnt1[1]), 32'd0);
    stepCycle();

    req0 = 1'b1; data0 = 8'hA5;
    stepCycle();
    checkOutput("single A5 data", 32'(o_data[0]), 32'hA5);
    stepCycle();
    checkOutput("single drained", 32'(o_valid[0]), 32'd0);

    // Hold the stage full under backpressure, then release it.
    out_ready = 1'b0;
    req0 = 1'b1; data0 = 8'h77;
    stepCycle();
    req1 = 1'b1; data1 = 8'h3C;
    repeat (4) stepCycle();
    checkOutput("backpressure hold", 32'(o_data[0]), 32'h77);
    out_ready = 1'b1;
    stepCycle();
    checkOutput("backpressure release", 32'(o_data[0]), 32'h3C);
    checkOutput("backpressure valid", 32'(o_valid[0]), 32'd1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle();
    end

    // Asynchronous reset between edges while the stage holds a byte.
    out_ready = 1'b0;
    req0 = 1'b1; data0 = 8'h5A;
    req1 = 1'b1; data1 = 8'hC3;
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d reset valid", k), 32'(o_valid[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset data", k), 32'(o_data[k]), 32'h00);
      checkOutput($sformatf("dut%0d reset cnt0", k), 32'(o_cnt0[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset cnt1", k), 32'(o_cnt1[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset ack0", k), 32'(o_ack0[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset ack1", k), 32'(o_ack1[k]), 32'd0);
    end
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_reqs = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post-reset first grant", 32'(o_ack0[0]), 32'd1);
    repeat (4) stepCycle();
    hold_reqs = 1'b0;

    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
